// File: rtl/vending_pkg.sv
// vending_pkg: shared types and helpers for the vending controller.
//   state_t      - controller state, 2-bit encoding
//   max_credit() - largest credit value representable in a given width
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  function automatic int max_credit(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/vending_timeout_ctr.sv
// vending_timeout_ctr: inactivity timer for the credit-accumulation phase.
// Only built when VEND_TIMEOUT_EN is defined; the default build has no timer.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - reload the timer (state entry or accepted coin)
//   enable    - count this cycle
//   expired   - TIMEOUT_CYC enabled cycles have passed since the last clear
`ifdef VEND_TIMEOUT_EN
module vending_timeout_ctr
  import vending_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count;

  // Down-counter: loaded with TIMEOUT_CYC-1, so the terminal count of zero is
  // seen on the TIMEOUT_CYC-th enabled cycle after a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= LOAD;
    end else if (clear) begin
      count <= LOAD;
    end else if (enable && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = enable && (count == '0);

endmodule
`endif

// File: rtl/vending_ctrl.sv
// vending_ctrl: coin-accumulating vending controller with a vend handshake,
// change return, cancel/refund and overflow coin rejection.
// Optional feature macro: VEND_TIMEOUT_EN (auto-refund after TIMEOUT_CYC idle
// cycles in ACCUM).
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   coin_valid, coin_val      - coin strobe and value (zero value ignored)
//   cancel                    - refund request level
//   coin_reject               - one-cycle pulse, coin returned uncredited
//   vend_valid, vend_ready    - dispense handshake
//   change_valid, change_amt,
//   change_ready              - change/refund handshake
//   total                     - current credit
//
// state  | meaning
// IDLE   | no credit, waiting for a first coin
// ACCUM  | credit below price, accepting coins or cancel
// VEND   | credit reached price, dispense requested
// CHANGE | change or refund requested
module vending_ctrl
  import vending_pkg::*;
#(
  parameter int CREDIT_W    = 5,
  parameter int COIN_W      = 3,
  parameter int PRICE       = 7,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [COIN_W-1:0]   coin_val,
  input  logic                cancel,
  output logic                coin_reject,
  output logic                vend_valid,
  input  logic                vend_ready,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  input  logic                change_ready,
  output logic [CREDIT_W-1:0] total
);

  localparam int MAX_CREDIT = max_credit(CREDIT_W);
  localparam int SUM_W      = ((CREDIT_W > COIN_W) ? CREDIT_W : COIN_W) + 1;
  localparam logic [SUM_W-1:0]    SUM_MAX   = SUM_W'(MAX_CREDIT);
  localparam logic [SUM_W-1:0]    SUM_PRICE = SUM_W'(PRICE);
  localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);

  if ((PRICE < 1) || (PRICE > MAX_CREDIT)) begin : g_price_chk
    $error("vending_ctrl: PRICE=%0d outside 1..%0d", PRICE, MAX_CREDIT);
  end
  if (TIMEOUT_CYC < 1) begin : g_timeout_chk
    $error("vending_ctrl: TIMEOUT_CYC=%0d must be at least 1", TIMEOUT_CYC);
  end

  state_t              state, state_nxt;
  logic [CREDIT_W-1:0] credit, credit_nxt;
  logic [CREDIT_W-1:0] amt, amt_nxt;
  logic                reject, reject_nxt;

  logic             coin_nz;
  logic [SUM_W-1:0] sum;
  logic             overflow;
  logic             at_price;
  logic             timeout_hit;

  assign coin_nz  = coin_valid && (coin_val != '0);
  // Sum is one bit wider than either operand so overflow is visible.
  assign sum      = SUM_W'(credit) + SUM_W'(coin_val);
  assign overflow = sum > SUM_MAX;
  assign at_price = sum >= SUM_PRICE;

`ifdef VEND_TIMEOUT_EN
  logic tmr_clear;

  assign tmr_clear = (state != ACCUM) || (coin_nz && !overflow && !cancel);

  vending_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .enable (state == ACCUM),
    .expired(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      credit <= '0;
      amt    <= '0;
      reject <= 1'b0;
    end else begin
      state  <= state_nxt;
      credit <= credit_nxt;
      amt    <= amt_nxt;
      reject <= reject_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    amt_nxt    = amt;
    reject_nxt = 1'b0;
    case (state)
      IDLE: begin
        // credit is zero here, so sum is just the coin value
        if (coin_nz) begin
          if (overflow) begin
            reject_nxt = 1'b1;
          end else begin
            credit_nxt = sum[CREDIT_W-1:0];
            state_nxt  = at_price ? VEND : ACCUM;
          end
        end
      end
      ACCUM: begin
        if (cancel) begin
          amt_nxt    = credit;
          state_nxt  = CHANGE;
          reject_nxt = coin_nz;
        end else if (coin_nz && !overflow) begin
          credit_nxt = sum[CREDIT_W-1:0];
          if (at_price) state_nxt = VEND;
        end else begin
          reject_nxt = coin_nz;
          if (timeout_hit) begin
            amt_nxt   = credit;
            state_nxt = CHANGE;
          end
        end
      end
      VEND: begin
        reject_nxt = coin_nz;
        if (vend_ready) begin
          amt_nxt = credit - PRICE_C;
          if (credit > PRICE_C) begin
            state_nxt = CHANGE;
          end else begin
            state_nxt  = IDLE;
            credit_nxt = '0;
          end
        end
      end
      CHANGE: begin
        reject_nxt = coin_nz;
        if (change_ready) begin
          credit_nxt = '0;
          amt_nxt    = '0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign vend_valid   = (state == VEND);
  assign change_valid = (state == CHANGE);
  assign change_amt   = amt;
  assign total        = credit;
  assign coin_reject  = reject;

endmodule

// File: tb/tb_vending_ctrl.sv
// tb_vending_ctrl: directed scenarios plus randomized stimulus checked against
// a behavioural credit model. Two instances: the default configuration and a
// 4-bit credit / price 15 instance for the overflow scenario.
module tb_vending_ctrl;

  localparam int PRICE   = 7;
  localparam int MAXC    = 31;
  localparam int TO      = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [2:0] coin_val = '0;
  logic       cancel = 1'b0;
  logic       vend_ready = 1'b0;
  logic       change_ready = 1'b0;

  logic       coin_reject, vend_valid, change_valid;
  logic [4:0] change_amt, total;
  logic       coin_reject_b, vend_valid_b, change_valid_b;
  logic [3:0] change_amt_b, total_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vending_ctrl #(.CREDIT_W(5), .COIN_W(3), .PRICE(PRICE), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_val(coin_val),
    .cancel(cancel), .coin_reject(coin_reject), .vend_valid(vend_valid),
    .vend_ready(vend_ready), .change_valid(change_valid), .change_amt(change_amt),
    .change_ready(change_ready), .total(total)
  );

  vending_ctrl #(.CREDIT_W(4), .COIN_W(3), .PRICE(15), .TIMEOUT_CYC(TO)) dut_b (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_val(coin_val),
    .cancel(cancel), .coin_reject(coin_reject_b), .vend_valid(vend_valid_b),
    .vend_ready(vend_ready), .change_valid(change_valid_b), .change_amt(change_amt_b),
    .change_ready(change_ready), .total(total_b)
  );

  // Inputs are driven at the falling edge and outputs sampled there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    coin_valid = 1'b0; coin_val = '0; cancel = 1'b0;
    vend_ready = 1'b0; change_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic coin(input int v);
    coin_valid = 1'b1;
    coin_val   = 3'(v);
    tick();
    coin_valid = 1'b0;
    coin_val   = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (total !== 5'd0) begin n_fail++; $display("FAIL reset_total: got %0d expected 0", total); end
    n_checks++; if (change_amt !== 5'd0) begin n_fail++; $display("FAIL reset_change_amt: got %0d expected 0", change_amt); end
    n_checks++; if (coin_reject !== 1'b0) begin n_fail++; $display("FAIL reset_coin_reject: got %b expected 0", coin_reject); end
    n_checks++; if (vend_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vend_valid: got %b expected 0", vend_valid); end
    n_checks++; if (change_valid !== 1'b0) begin n_fail++; $display("FAIL reset_change_valid: got %b expected 0", change_valid); end
    rst = 1'b0;
  endtask

  task automatic test_exact_price();
    int coins[3];
    int sums[3];
    coins = '{2, 2, 3};
    sums  = '{2, 4, 7};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      coin(coins[i]);
      n_checks++; if (total !== 5'(sums[i])) begin n_fail++; $display("FAIL exact_total[%0d]: got %0d expected %0d", i, total, sums[i]); end
      n_checks++; if (vend_valid !== (i == 2)) begin n_fail++; $display("FAIL exact_vend_valid[%0d]: got %b expected %b", i, vend_valid, i == 2); end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (vend_valid !== 1'b1) begin n_fail++; $display("FAIL exact_vend_hold[%0d]: got %b expected 1", i, vend_valid); end
    end
    vend_ready = 1'b1;
    tick();
    vend_ready = 1'b0;
    n_checks++; if (vend_valid !== 1'b0) begin n_fail++; $display("FAIL exact_vend_drop: got %b expected 0", vend_valid); end
    n_checks++; if (total !== 5'd0) begin n_fail++; $display("FAIL exact_total_after: got %0d expected 0", total); end
    tick();
    n_checks++; if (change_valid !== 1'b0) begin n_fail++; $display("FAIL exact_no_change: got %b expected 0", change_valid); end
  endtask

  task automatic test_change();
    do_reset();
    coin(3); coin(3); coin(3);
    n_checks++; if (total !== 5'd9) begin n_fail++; $display("FAIL change_total: got %0d expected 9", total); end
    n_checks++; if (vend_valid !== 1'b1) begin n_fail++; $display("FAIL change_vend_valid: got %b expected 1", vend_valid); end
    vend_ready = 1'b1;
    tick();
    vend_ready = 1'b0;
    n_checks++; if (change_valid !== 1'b1) begin n_fail++; $display("FAIL change_valid: got %b expected 1", change_valid); end
    n_checks++; if (change_amt !== 5'd2) begin n_fail++; $display("FAIL change_amt: got %0d expected 2", change_amt); end
    tick();
    n_checks++; if (change_valid !== 1'b1) begin n_fail++; $display("FAIL change_hold: got %b expected 1", change_valid); end
    change_ready = 1'b1;
    tick();
    change_ready = 1'b0;
    n_checks++; if (change_valid !== 1'b0) begin n_fail++; $display("FAIL change_drop: got %b expected 0", change_valid); end
    n_checks++; if (total !== 5'd0) begin n_fail++; $display("FAIL change_total_after: got %0d expected 0", total); end
    n_checks++; if (change_amt !== 5'd0) begin n_fail++; $display("FAIL change_amt_after: got %0d expected 0", change_amt); end
  endtask

  task automatic test_cancel();
    do_reset();
    coin(2); coin(3);
    cancel = 1'b1; coin_valid = 1'b1; coin_val = 3'd2;
    tick();
    cancel = 1'b0; coin_valid = 1'b0; coin_val = '0;
    n_checks++; if (coin_reject !== 1'b1) begin n_fail++; $display("FAIL cancel_reject: got %b expected 1", coin_reject); end
    n_checks++; if (change_valid !== 1'b1) begin n_fail++; $display("FAIL cancel_change_valid: got %b expected 1", change_valid); end
    n_checks++; if (change_amt !== 5'd5) begin n_fail++; $display("FAIL cancel_change_amt: got %0d expected 5", change_amt); end
    n_checks++; if (total !== 5'd5) begin n_fail++; $display("FAIL cancel_total: got %0d expected 5", total); end
    tick();
    n_checks++; if (coin_reject !== 1'b0) begin n_fail++; $display("FAIL cancel_reject_pulse: got %b expected 0", coin_reject); end
    change_ready = 1'b1;
    tick();
    change_ready = 1'b0;
    n_checks++; if (change_valid !== 1'b0) begin n_fail++; $display("FAIL cancel_idle: got %b expected 0", change_valid); end
    n_checks++; if (total !== 5'd0) begin n_fail++; $display("FAIL cancel_total_after: got %0d expected 0", total); end
    // cancel with no credit is ignored
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    n_checks++; if (change_valid !== 1'b0) begin n_fail++; $display("FAIL cancel_in_idle: got %b expected 0", change_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    coin(4); coin(4); coin(4);
    n_checks++; if (total_b !== 4'd12) begin n_fail++; $display("FAIL ovf_total12: got %0d expected 12", total_b); end
    coin(4);
    n_checks++; if (coin_reject_b !== 1'b1) begin n_fail++; $display("FAIL ovf_reject: got %b expected 1", coin_reject_b); end
    n_checks++; if (total_b !== 4'd12) begin n_fail++; $display("FAIL ovf_total_kept: got %0d expected 12", total_b); end
    coin(3);
    n_checks++; if (coin_reject_b !== 1'b0) begin n_fail++; $display("FAIL ovf_accept: got %b expected 0", coin_reject_b); end
    n_checks++; if (total_b !== 4'd15) begin n_fail++; $display("FAIL ovf_total15: got %0d expected 15", total_b); end
    n_checks++; if (vend_valid_b !== 1'b1) begin n_fail++; $display("FAIL ovf_vend: got %b expected 1", vend_valid_b); end
    vend_ready = 1'b1;
    tick();
    vend_ready = 1'b0;
    n_checks++; if (change_valid_b !== 1'b0) begin n_fail++; $display("FAIL ovf_no_change: got %b expected 0", change_valid_b); end
    n_checks++; if (total_b !== 4'd0) begin n_fail++; $display("FAIL ovf_total_after: got %0d expected 0", total_b); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    coin(4); coin(4);
    n_checks++; if (vend_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_vend: got %b expected 1", vend_valid); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (vend_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_vend_async: got %b expected 0", vend_valid); end
    n_checks++; if (total !== 5'd0) begin n_fail++; $display("FAIL rstmid_total_async: got %0d expected 0", total); end
    @(negedge clk);
    rst = 1'b0;
    coin(7);
    n_checks++; if (vend_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_direct_vend: got %b expected 1", vend_valid); end
    n_checks++; if (total !== 5'd7) begin n_fail++; $display("FAIL rstmid_total7: got %0d expected 7", total); end
    vend_ready = 1'b1;
    tick();
    vend_ready = 1'b0;
    n_checks++; if (change_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_change: got %b expected 0", change_valid); end
    n_checks++; if (vend_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got %b expected 0", vend_valid); end
  endtask

  task automatic test_zero_coin();
    do_reset();
    coin(0);
    n_checks++; if (total !== 5'd0) begin n_fail++; $display("FAIL zero_idle_total: got %0d expected 0", total); end
    n_checks++; if (coin_reject !== 1'b0) begin n_fail++; $display("FAIL zero_idle_reject: got %b expected 0", coin_reject); end
    coin(4); coin(4);
    coin(0);
    n_checks++; if (coin_reject !== 1'b0) begin n_fail++; $display("FAIL zero_vend_reject: got %b expected 0", coin_reject); end
    coin(1);
    n_checks++; if (coin_reject !== 1'b1) begin n_fail++; $display("FAIL vend_coin_reject: got %b expected 1", coin_reject); end
    n_checks++; if (total !== 5'd8) begin n_fail++; $display("FAIL vend_coin_total: got %0d expected 8", total); end
    vend_ready = 1'b1;
    tick();
    vend_ready = 1'b0;
    n_checks++; if (change_amt !== 5'd1) begin n_fail++; $display("FAIL zero_change_amt: got %0d expected 1", change_amt); end
    coin(2);
    n_checks++; if (coin_reject !== 1'b1) begin n_fail++; $display("FAIL change_coin_reject: got %b expected 1", coin_reject); end
    change_ready = 1'b1;
    tick();
    change_ready = 1'b0;
  endtask

`ifdef VEND_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    coin(2);
    repeat (TO - 1) tick();
    n_checks++; if (change_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b expected 0", change_valid); end
    tick();
    n_checks++; if (change_valid !== 1'b1) begin n_fail++; $display("FAIL timeout_refund: got %b expected 1", change_valid); end
    n_checks++; if (change_amt !== 5'd2) begin n_fail++; $display("FAIL timeout_amt: got %0d expected 2", change_amt); end
    change_ready = 1'b1;
    tick();
    change_ready = 1'b0;
    coin(2);
    repeat (TO - 2) tick();
    coin(1);
    n_checks++; if (total !== 5'd3) begin n_fail++; $display("FAIL timeout_restart_total: got %0d expected 3", total); end
    repeat (TO - 1) tick();
    n_checks++; if (change_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_restart: got %b expected 0", change_valid); end
    tick();
    n_checks++; if (change_amt !== 5'd3) begin n_fail++; $display("FAIL timeout_restart_amt: got %0d expected 3", change_amt); end
    change_ready = 1'b1;
    tick();
    change_ready = 1'b0;
  endtask
`else
  task automatic test_timeout();
    do_reset();
    coin(2);
    repeat (4 * TO) tick();
    n_checks++; if (change_valid !== 1'b0) begin n_fail++; $display("FAIL no_timeout_change: got %b expected 0", change_valid); end
    n_checks++; if (total !== 5'd2) begin n_fail++; $display("FAIL no_timeout_total: got %0d expected 2", total); end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    change_ready = 1'b1;
    tick();
    change_ready = 1'b0;
  endtask
`endif

  // Reference model: credit accumulates coins; a pending dispense or a pending
  // change request blocks (rejects) coins; cancel refunds any nonzero credit.
  task automatic test_random();
    int  credit = 0;
    int  amt    = 0;
    int  idle   = 0;
    bit  vend_pend = 0;
    bit  chg_pend  = 0;
    bit  rej;
    bit  cv, cn, vr, cr, has_coin;
    int  val;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      cv  = ($urandom_range(0, 1) == 1);
      val = $urandom_range(0, 7);
      cn  = ($urandom_range(0, 15) == 0);
      vr  = ($urandom_range(0, 2) == 0);
      cr  = ($urandom_range(0, 2) == 0);
      coin_valid = cv; coin_val = 3'(val); cancel = cn;
      vend_ready = vr; change_ready = cr;
      has_coin = cv && (val != 0);
      rej = 0;
      if (vend_pend) begin
        rej = has_coin;
        if (vr) begin
          vend_pend = 0;
          if (credit > PRICE) begin chg_pend = 1; amt = credit - PRICE; end
          else credit = 0;
        end
      end else if (chg_pend) begin
        rej = has_coin;
        if (cr) begin chg_pend = 0; credit = 0; amt = 0; end
      end else if (cn && credit > 0) begin
        rej = has_coin; chg_pend = 1; amt = credit; idle = 0;
      end else if (has_coin && (credit + val <= MAXC)) begin
        credit += val; idle = 0;
        if (credit >= PRICE) vend_pend = 1;
      end else begin
        rej = has_coin;
`ifdef VEND_TIMEOUT_EN
        if (credit > 0) begin
          idle++;
          if (idle == TO) begin chg_pend = 1; amt = credit; idle = 0; end
        end
`endif
      end
      tick();
      n_checks++; if (total !== 5'(credit)) begin n_fail++; $display("FAIL rand_total@%0d: got %0d expected %0d", cyc, total, credit); end
      n_checks++; if (vend_valid !== vend_pend) begin n_fail++; $display("FAIL rand_vend_valid@%0d: got %b expected %b", cyc, vend_valid, vend_pend); end
      n_checks++; if (change_valid !== chg_pend) begin n_fail++; $display("FAIL rand_change_valid@%0d: got %b expected %b", cyc, change_valid, chg_pend); end
      n_checks++; if (change_amt !== 5'(amt)) begin n_fail++; $display("FAIL rand_change_amt@%0d: got %0d expected %0d", cyc, change_amt, amt); end
      n_checks++; if (coin_reject !== rej) begin n_fail++; $display("FAIL rand_coin_reject@%0d: got %b expected %b", cyc, coin_reject, rej); end
    end
    coin_valid = 1'b0; coin_val = '0; cancel = 1'b0;
    vend_ready = 1'b0; change_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_exact_price();
    test_change();
    test_cancel();
    test_overflow();
    test_reset_mid();
    test_zero_coin();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
